fifo_stream_reader: RTL

- Read-side drain for the team's register-based FIFO.
- Pops words from the FIFO's first-word-fall-through read port (head data, empty flag, read enable) and presents them as a registered valid/ready stream.
- Groups the stream into fixed-length packets with a last-beat marker and a count of completed packets.
- Sits between a FIFO instance and any downstream consumer, such as a UART transmitter or packet sink.

---
 rtl/fifo_stream_reader.sv | 127 ++++++++++++
 1 files changed

// File: rtl/fifo_stream_reader.sv
// Read-side drain for a first-word-fall-through FIFO. It presents FIFO words as a
// registered valid/ready stream, grouped into fixed-length packets with a last-beat flag.
module fifo_stream_reader #(
    parameter int g_WIDTH     = 8,
    parameter int g_PKT_LEN   = 4,
    parameter int g_CNT_WIDTH = 16
) (
    input  logic                   i_clk,
    input  logic                   i_rst_n,
    input  logic                   i_enable,
    input  logic                   i_clear,
    input  logic [g_WIDTH-1:0]     i_fifo_rd_data,
    input  logic                   i_fifo_empty,
    output logic                   o_fifo_rd_en,
    output logic                   o_valid,
    output logic [g_WIDTH-1:0]     o_data,
    output logic                   o_last,
    input  logic                   i_ready,
    output logic [g_CNT_WIDTH-1:0] o_pkt_count
);

    localparam int c_BEAT_W = (g_PKT_LEN > 1) ? $clog2(g_PKT_LEN) : 1;
    localparam logic [c_BEAT_W-1:0] c_LAST_BEAT = c_BEAT_W'(g_PKT_LEN - 1);

    typedef enum logic [1:0] {
        ST_EMPTY,
        ST_ONE,
        ST_TWO
    } state_t;

    state_t                 state_q, state_d;
    logic [g_WIDTH-1:0]     main_q, skid_q;
    logic [c_BEAT_W-1:0]    beat_q;
    logic [g_CNT_WIDTH-1:0] pkt_cnt_q;
    logic                   push, pop;
    logic                   load_main_head, load_main_skid, load_skid;

    // NOTE: push is gated by reset so the FIFO is never popped while this block is held in reset.
    assign push         = i_rst_n && i_enable && !i_fifo_empty && (state_q != ST_TWO) && !i_clear;
    assign o_fifo_rd_en = push;
    assign o_valid      = (state_q != ST_EMPTY);
    assign pop          = o_valid && i_ready;
    assign o_last       = o_valid && (beat_q == c_LAST_BEAT);
    assign o_data       = main_q;
    assign o_pkt_count  = pkt_cnt_q;

    // NOTE: non-blocking assignments for all state so every register samples pre-edge values.
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            state_q <= ST_EMPTY;
        end else begin
            state_q <= state_d;
        end
    end

    // NOTE: every output of this block gets a default first, so no latch is inferred.
    always_comb begin
        state_d        = state_q;
        load_main_head = 1'b0;
        load_main_skid = 1'b0;
        load_skid      = 1'b0;
        if (i_clear) begin
            state_d = ST_EMPTY;
        end else begin
            unique case (state_q)
                ST_EMPTY: begin
                    if (push) begin
                        state_d        = ST_ONE;
                        load_main_head = 1'b1;
                    end
                end
                ST_ONE: begin
                    if (push && !pop) begin
                        state_d   = ST_TWO;
                        load_skid = 1'b1;
                    end else if (push && pop) begin
                        load_main_head = 1'b1;
                    end else if (pop) begin
                        state_d = ST_EMPTY;
                    end
                end
                ST_TWO: begin
                    if (pop) begin
                        state_d        = ST_ONE;
                        load_main_skid = 1'b1;
                    end
                end
                default: state_d = ST_EMPTY;
            endcase
        end
    end

    // NOTE: the data registers are reset because o_data must read zero out of reset.
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            main_q <= '0;
            skid_q <= '0;
        end else begin
            if (load_main_head) begin
                main_q <= i_fifo_rd_data;
            end else if (load_main_skid) begin
                main_q <= skid_q;
            end
            if (load_skid) begin
                skid_q <= i_fifo_rd_data;
            end
        end
    end

    // Beat position survives i_enable=0; only clear or reset rewinds it.
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            beat_q    <= '0;
            pkt_cnt_q <= '0;
        end else if (i_clear) begin
            beat_q <= '0;
        end else if (pop) begin
            if (beat_q == c_LAST_BEAT) begin
                beat_q    <= '0;
                pkt_cnt_q <= pkt_cnt_q + g_CNT_WIDTH'(1);
            end else begin
                beat_q <= beat_q + c_BEAT_W'(1);
            end
        end
    end

endmodule
